// File: rtl/otter_lsu.sv
// OTTER data-side load/store unit: one transaction at a time, misaligned
// half/word accesses split into byte beats, per-beat timeout to an error completion.
module otter_lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LSU_REQ,
  input  logic        LSU_WE,
  input  logic [31:0] LSU_ADDR,
  input  logic [31:0] LSU_WDATA,
  input  logic [1:0]  LSU_SIZE,
  input  logic        LSU_SIGN,
  output logic        LSU_BUSY,
  output logic        LSU_DONE,
  output logic [31:0] LSU_RDATA,
  output logic        LSU_ERR,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  input  logic        MEM_VALID2
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          sign_q, sign_d;
  logic          split_q, split_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    beat_q, beat_d;
  logic [31:0]   acc_q, acc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rden_q, rden_d;
  logic          wen_q, wen_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   mdin_q, mdin_d;
  logic [1:0]    msize_q, msize_d;
  logic          msign_q, msign_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          issue_new;
  logic          in_split;
  logic [1:0]    in_last;
  logic          src_we, src_split, src_sign;
  logic [31:0]   src_addr, src_wdata;
  logic [1:0]    src_size, src_beat;
  logic [31:0]   iss_addr, iss_din;
  logic [1:0]    iss_size;
  logic          iss_sign;
  logic [31:0]   ld_res;
  logic          tmo_hit;

  assign in_split = ((LSU_SIZE == 2'd1) && LSU_ADDR[0]) ||
                    (LSU_SIZE[1] && (LSU_ADDR[1:0] != 2'b00));
  assign in_last  = !in_split ? 2'd0 : ((LSU_SIZE == 2'd1) ? 2'd1 : 2'd3);

  // Beat being launched: a fresh request starts at beat 0, a GAP advances to the next byte.
  assign issue_new = (state_q == IDLE) || (state_q == DONE);
  assign src_we    = issue_new ? LSU_WE    : we_q;
  assign src_addr  = issue_new ? LSU_ADDR  : addr_q;
  assign src_wdata = issue_new ? LSU_WDATA : wdata_q;
  assign src_size  = issue_new ? LSU_SIZE  : size_q;
  assign src_sign  = issue_new ? LSU_SIGN  : sign_q;
  assign src_split = issue_new ? in_split  : split_q;
  assign src_beat  = issue_new ? 2'd0      : beat_q + 2'd1;

  assign iss_addr = src_split ? src_addr + {30'b0, src_beat} : src_addr;
  assign iss_din  = src_split ? {24'b0, src_wdata[{src_beat, 3'b000} +: 8]} : src_wdata;
  assign iss_size = src_split ? 2'd0 : src_size;
  assign iss_sign = src_split ? 1'b1 : src_sign;

  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));

  // Final load value: merge the last byte, then extend a split halfword locally.
  always_comb begin
    ld_res = acc_q;
    ld_res[{beat_q, 3'b000} +: 8] = MEM_DOUT2[7:0];
    if (size_q == 2'd1) ld_res[31:16] = sign_q ? 16'h0000 : {16{ld_res[15]}};
    if (!split_q) ld_res = MEM_DOUT2;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sign_d  = sign_q;
    split_d = split_q;
    last_d  = last_q;
    beat_d  = beat_q;
    acc_d   = acc_q;
    tmo_d   = tmo_q;
    rden_d  = rden_q;
    wen_d   = wen_q;
    maddr_d = maddr_q;
    mdin_d  = mdin_q;
    msize_d = msize_q;
    msign_d = msign_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (LSU_REQ) begin
          we_d    = LSU_WE;
          addr_d  = LSU_ADDR;
          wdata_d = LSU_WDATA;
          size_d  = LSU_SIZE;
          sign_d  = LSU_SIGN;
          split_d = in_split;
          last_d  = in_last;
          beat_d  = 2'd0;
          acc_d   = 32'h0;
          tmo_d   = '0;
          rden_d  = !src_we;
          wen_d   = src_we;
          maddr_d = iss_addr;
          mdin_d  = iss_din;
          msize_d = iss_size;
          msign_d = iss_sign;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (MEM_VALID2) begin
          rden_d = 1'b0;
          wen_d  = 1'b0;
          if (beat_q == last_q) begin
            err_d   = 1'b0;
            if (!we_q) rdata_d = ld_res;
            state_d = DONE;
          end else begin
            acc_d[{beat_q, 3'b000} +: 8] = MEM_DOUT2[7:0];
            state_d = GAP;
          end
        end else if (tmo_hit) begin
          rden_d  = 1'b0;
          wen_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        beat_d  = src_beat;
        tmo_d   = '0;
        rden_d  = !we_q;
        wen_d   = we_q;
        maddr_d = iss_addr;
        mdin_d  = iss_din;
        msize_d = iss_size;
        msign_d = iss_sign;
        state_d = ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      split_q <= 1'b0;
      last_q  <= 2'd0;
      beat_q  <= 2'd0;
      acc_q   <= 32'h0;
      tmo_q   <= '0;
      rden_q  <= 1'b0;
      wen_q   <= 1'b0;
      maddr_q <= 32'h0;
      mdin_q  <= 32'h0;
      msize_q <= 2'd0;
      msign_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      split_q <= split_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      tmo_q   <= tmo_d;
      rden_q  <= rden_d;
      wen_q   <= wen_d;
      maddr_q <= maddr_d;
      mdin_q  <= mdin_d;
      msize_q <= msize_d;
      msign_q <= msign_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign LSU_BUSY  = (state_q == ACCESS) || (state_q == GAP);
  assign LSU_DONE  = (state_q == DONE);
  assign LSU_RDATA = rdata_q;
  assign LSU_ERR   = err_q;
  assign MEM_RDEN2 = rden_q;
  assign MEM_WE2   = wen_q;
  assign MEM_ADDR2 = maddr_q;
  assign MEM_DIN2  = mdin_q;
  assign MEM_SIZE  = msize_q;
  assign MEM_SIGN  = msign_q;

endmodule

// File: tb/tb_otter_lsu.sv
// Directed bench for otter_lsu: a default-timeout unit for functional traffic
// and a TIMEOUT=8 unit for the error path.
module tb_otter_lsu;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        LSU_REQ, LSU_WE, LSU_SIGN, req_t;
  logic [31:0] LSU_ADDR, LSU_WDATA, MEM_DOUT2;
  logic [1:0]  LSU_SIZE;
  logic        MEM_VALID2, valid_t;

  logic        busy, done, err, rden, wen, msign;
  logic [31:0] rdata, maddr, mdin;
  logic [1:0]  msize;
  logic        t_busy, t_done, t_err, t_rden, t_wen, t_msign;
  logic [31:0] t_rdata, t_maddr, t_mdin;
  logic [1:0]  t_msize;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  otter_lsu dut (
    .CLK(CLK), .RST_N(RST_N), .LSU_REQ(LSU_REQ), .LSU_WE(LSU_WE),
    .LSU_ADDR(LSU_ADDR), .LSU_WDATA(LSU_WDATA), .LSU_SIZE(LSU_SIZE), .LSU_SIGN(LSU_SIGN),
    .LSU_BUSY(busy), .LSU_DONE(done), .LSU_RDATA(rdata), .LSU_ERR(err),
    .MEM_RDEN2(rden), .MEM_WE2(wen), .MEM_ADDR2(maddr), .MEM_DIN2(mdin),
    .MEM_SIZE(msize), .MEM_SIGN(msign), .MEM_DOUT2(MEM_DOUT2), .MEM_VALID2(MEM_VALID2)
  );

  otter_lsu #(.TIMEOUT(8)) dut_t (
    .CLK(CLK), .RST_N(RST_N), .LSU_REQ(req_t), .LSU_WE(LSU_WE),
    .LSU_ADDR(LSU_ADDR), .LSU_WDATA(LSU_WDATA), .LSU_SIZE(LSU_SIZE), .LSU_SIGN(LSU_SIGN),
    .LSU_BUSY(t_busy), .LSU_DONE(t_done), .LSU_RDATA(t_rdata), .LSU_ERR(t_err),
    .MEM_RDEN2(t_rden), .MEM_WE2(t_wen), .MEM_ADDR2(t_maddr), .MEM_DIN2(t_mdin),
    .MEM_SIZE(t_msize), .MEM_SIGN(t_msign), .MEM_DOUT2(MEM_DOUT2), .MEM_VALID2(valid_t)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic sg);
    LSU_WE = we; LSU_ADDR = a; LSU_WDATA = wd; LSU_SIZE = sz; LSU_SIGN = sg;
    LSU_REQ = 1'b1;
    tick();
    LSU_REQ = 1'b0;
  endtask

  // Called in a strobe cycle: checks the beat, waits, then answers with VALID.
  task automatic do_beat(input string tag, input logic we, input logic [31:0] a,
                         input logic [31:0] din, input logic [1:0] sz, input logic sg,
                         input logic [31:0] dout, input int waitc);
    chk({tag, ".rden"}, {31'b0, rden}, {31'b0, !we});
    chk({tag, ".we"},   {31'b0, wen},  {31'b0, we});
    chk({tag, ".addr"}, maddr, a);
    chk({tag, ".size"}, {30'b0, msize}, {30'b0, sz});
    chk({tag, ".sign"}, {31'b0, msign}, {31'b0, sg});
    if (we) chk({tag, ".din"}, mdin, din);
    repeat (waitc) tick();
    if (waitc > 0) chk({tag, ".addr_hold"}, maddr, a);
    MEM_VALID2 = 1'b1; MEM_DOUT2 = dout;
    tick();
    MEM_VALID2 = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; LSU_REQ = 1'b0; req_t = 1'b0; LSU_WE = 1'b0; LSU_SIGN = 1'b0;
    LSU_ADDR = 32'h0; LSU_WDATA = 32'h0; LSU_SIZE = 2'd0;
    MEM_DOUT2 = 32'h0; MEM_VALID2 = 1'b0; valid_t = 1'b0;
    #2;
    chk("rst.outs", {rden, wen, msign, busy, done, err, msize}, 8'h0);
    chk("rst.addr", maddr, 32'h0);
    chk("rst.din", mdin, 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Aligned LW, VALID 10 cycles after the strobe
    req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    chk("lw.busy", {31'b0, busy}, 32'd1);
    do_beat("lw", 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 10);
    chk("lw.done", {31'b0, done}, 32'd1);
    chk("lw.rdata", rdata, 32'hDEADBEEF);
    chk("lw.err", {31'b0, err}, 32'd0);
    chk("lw.rden_off", {31'b0, rden}, 32'd0);
    tick();
    chk("lw.done_pulse", {31'b0, done}, 32'd0);

    // LH signed at 0x203: two byte reads with a GAP between
    req(1'b0, 32'h203, 32'h0, 2'd1, 1'b0);
    do_beat("lh0", 1'b0, 32'h203, 32'h0, 2'd0, 1'b1, 32'hAABBCC34, 0);
    chk("lh.gap_rden", {31'b0, rden}, 32'd0);
    chk("lh.gap_busy", {31'b0, busy}, 32'd1);
    tick();
    do_beat("lh1", 1'b0, 32'h204, 32'h0, 2'd0, 1'b1, 32'h11223380, 1);
    chk("lh.done", {31'b0, done}, 32'd1);
    chk("lh.rdata", rdata, 32'hFFFF8034);
    tick();

    // SW at 0x101: four byte writes, single DONE
    req(1'b1, 32'h101, 32'h11223344, 2'd2, 1'b0);
    do_beat("sw0", 1'b1, 32'h101, 32'h44, 2'd0, 1'b1, 32'h0, 0);
    chk("sw.gap0_done", {31'b0, done}, 32'd0);
    tick();
    do_beat("sw1", 1'b1, 32'h102, 32'h33, 2'd0, 1'b1, 32'h0, 2);
    tick();
    do_beat("sw2", 1'b1, 32'h103, 32'h22, 2'd0, 1'b1, 32'h0, 0);
    tick();
    do_beat("sw3", 1'b1, 32'h104, 32'h11, 2'd0, 1'b1, 32'h0, 0);
    chk("sw.done", {31'b0, done}, 32'd1);
    chk("sw.err", {31'b0, err}, 32'd0);
    tick();
    chk("sw.done_once", {31'b0, done}, 32'd0);

    // Timeout: VALID never arrives on the TIMEOUT=8 unit
    LSU_WE = 1'b0; LSU_ADDR = 32'h40; LSU_SIZE = 2'd2; LSU_SIGN = 1'b0;
    req_t = 1'b1; tick(); req_t = 1'b0;
    chk("to.rden1", {31'b0, t_rden}, 32'd1);
    repeat (7) tick();
    chk("to.rden8", {31'b0, t_rden}, 32'd1);
    chk("to.nodone8", {31'b0, t_done}, 32'd0);
    tick();
    chk("to.rden_off", {31'b0, t_rden}, 32'd0);
    chk("to.done", {31'b0, t_done}, 32'd1);
    chk("to.err", {31'b0, t_err}, 32'd1);
    chk("to.rdata", t_rdata, 32'h0);
    tick();
    // VALID in the 8th cycle beats the timeout
    req_t = 1'b1; tick(); req_t = 1'b0;
    repeat (7) tick();
    valid_t = 1'b1; MEM_DOUT2 = 32'h12345678;
    tick();
    valid_t = 1'b0;
    chk("to8.done", {31'b0, t_done}, 32'd1);
    chk("to8.err", {31'b0, t_err}, 32'd0);
    chk("to8.rdata", t_rdata, 32'h12345678);
    tick();

    // Reset during the second beat of a split store
    req(1'b1, 32'h101, 32'h11223344, 2'd2, 1'b0);
    do_beat("rsw0", 1'b1, 32'h101, 32'h44, 2'd0, 1'b1, 32'h0, 0);
    tick();
    chk("rsw.we_beat1", {31'b0, wen}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rsw.we_async", {31'b0, wen}, 32'd0);
    chk("rsw.busy", {31'b0, busy}, 32'd0);
    tick();
    chk("rsw.nodone", {31'b0, done}, 32'd0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("rsw.idle_done", {31'b0, done}, 32'd0);
    req(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    do_beat("lb", 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'hFFFFFFF0, 1);
    chk("lb.done", {31'b0, done}, 32'd1);
    chk("lb.rdata", rdata, 32'hFFFFFFF0);
    tick();

    // Back-to-back: REQ held through DONE; changes while BUSY ignored
    LSU_WE = 1'b0; LSU_ADDR = 32'h200; LSU_SIZE = 2'd2; LSU_SIGN = 1'b0; LSU_REQ = 1'b1;
    tick();
    chk("b2b.addr1", maddr, 32'h200);
    LSU_ADDR = 32'h300;
    MEM_VALID2 = 1'b1; MEM_DOUT2 = 32'hA5A5A5A5;
    tick();
    MEM_VALID2 = 1'b0;
    chk("b2b.done1", {31'b0, done}, 32'd1);
    chk("b2b.rdata1", rdata, 32'hA5A5A5A5);
    tick();
    LSU_REQ = 1'b0;
    chk("b2b.rden2", {31'b0, rden}, 32'd1);
    chk("b2b.addr2", maddr, 32'h300);
    chk("b2b.nodone", {31'b0, done}, 32'd0);
    LSU_WE = 1'b1; LSU_ADDR = 32'h999; LSU_REQ = 1'b1;
    tick();
    LSU_REQ = 1'b0;
    chk("b2b.ign_addr", maddr, 32'h300);
    chk("b2b.ign_we", {31'b0, wen}, 32'd0);
    MEM_VALID2 = 1'b1; MEM_DOUT2 = 32'h0BADF00D;
    tick();
    MEM_VALID2 = 1'b0;
    chk("b2b.rdata2", rdata, 32'h0BADF00D);
    tick();
    chk("b2b.idle", {30'b0, busy, wen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
